uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single UART transmitter between NREQ byte-stream requesters. Typical requesters are the board display streamer, the banner/string printer and the key-echo/status path.
- Grants are round-robin and packet-locked. Once a requester is granted, it keeps the transmitter until it sends a byte flagged last, so multi-byte sequences (ESC [ ; H, CR LF, whole board frames) are never interleaved.
- The block sits between the requesters and the UARTTransmitter instance. It owns the transmitter's valid/ready handshake.

## Interface

Parameters:
- NREQ, 3: number of requesters (2..8).
- HOLD_MAX, 4096: idle cycles a locked requester may go without offering a byte before its lock is revoked. 0 disables the timeout.

Ports:
- clk  in  1  system clock (48 MHz).
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- req_valid  in  NREQ  requester i offers a byte.
- req_data  in  8*NREQ  byte of requester i at [8i+7:8i].
- req_last  in  NREQ  byte of requester i closes its packet.
- req_ready  out  NREQ  byte of requester i consumed this cycle.
- grant  out  NREQ  one-hot lock owner; all zero when unlocked.
- tx_valid  out  1  to UARTTransmitter valid.
- tx_data  out  8  to UARTTransmitter in.
- tx_ready  in  1  from UARTTransmitter ready.
- timeout_pulse  out  1  one-cycle pulse when a lock is revoked by HOLD_MAX.

## Operation

States are IDLE, FETCH, SEND and ACK.

- Reset values:
  - state IDLE, grant 0, req_ready 0, tx_valid 0, tx_data 8'h00, timeout_pulse 0.
  - rr_ptr = NREQ-1, so requester 0 wins the first arbitration.
  - hold_cnt 0, last_q 0.
- IDLE:
  - If any req_valid is high, pick the first asserted index scanning rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Register the winner in grant (one-hot), clear hold_cnt, and go to FETCH.
- FETCH (owner g):
  - req_ready[g] = req_valid[g] (combinational, only in FETCH). Every other req_ready bit is 0.
  - On transfer, latch req_data[g] into tx_data and req_last[g] into last_q, then go to SEND.
  - With no transfer, hold_cnt increments.
  - When hold_cnt reaches HOLD_MAX (HOLD_MAX≠0): pulse timeout_pulse, set rr_ptr=g, clear grant, go to IDLE.
- SEND: when tx_ready=1, set tx_valid<=1 and go to ACK.
- ACK:
  - Hold tx_valid=1 until tx_ready is sampled 0 (transmitter busy, byte accepted). Then set tx_valid<=0.
  - If last_q: set rr_ptr=g, clear grant, go to IDLE.
  - Otherwise clear hold_cnt and return to FETCH.
- Requesters must hold req_data, req_last and req_valid stable from assertion until req_ready. The arbiter never consumes a byte from a non-owner.
- A single-byte packet (req_last=1 on its first byte) is legal.
- Simultaneous requests: only the round-robin winner is granted. Losers wait; they are not dropped.
- Async reset mid-packet drops the in-flight byte. tx_valid falls immediately. A byte already accepted by the transmitter finishes on the line (transmitter's own behaviour).

## Timing

- IDLE with req_valid seen → grant registered next edge; req_ready can assert in that next cycle.
- Byte accepted in FETCH (cycle N) → SEND at N+1. If tx_ready=1, tx_valid=1 from N+2.
- tx_valid falls on the edge after tx_ready is sampled low.
- Back-to-back bytes of one packet: FETCH is re-entered the cycle after tx_valid falls, so there is no added gap beyond one character time.
- Lock release → new arbitration the following cycle. The minimum IDLE dwell is 1 cycle between packets.
- hold_cnt width is clog2(HOLD_MAX+1). It saturates and never wraps. The timeout fires exactly HOLD_MAX cycles after FETCH entry with no transfer.

## Structure

- The shared package/include conway_pkg holds:
  - The arbiter state encoding (IDLE=0, FETCH=1, SEND=2, ACK=3).
  - The byte width constant (8).
  - The ASCII constants already used by the display path (ESC, '[', ';', 'H', CR, LF).
- One sub-module, rr_pick: purely combinational round-robin picker. Inputs are a request vector and rr_ptr; outputs are a one-hot winner and an any flag.
- Everything else (FSM, hold counter, data latch) stays in uart_tx_arbiter.

## Test plan

- Single requester, packet 8'h1B,8'h5B,8'h3B,8'h48 (last on 8'h48) → four tx_valid strobes in order, grant=3'b001 throughout, grant=0 after the fourth byte.
- Requesters 0 and 2 both request at reset release, each with 2-byte packets "AB" and "CD" → line carries A,B,C,D; a new request on 0 then wins only after requester 2 is served.
- Requester 1 streams "xyz" while requester 0 asserts valid mid-packet → no interleave; line carries x,y,z then 0's byte.
- HOLD_MAX=16, requester 0 sends one non-last byte then drops valid → timeout_pulse exactly 16 cycles after FETCH entry, grant=0, pending requester 1 is granted next.
- rst_n pulsed low while in ACK → tx_valid, grant and req_ready go 0 asynchronously; after release, requester 0 has priority again.
- tx_ready held low for 100 cycles while in SEND → tx_valid stays 0 until tx_ready=1, then the byte is issued exactly once.

Source files
------------

// File: rtl/conway_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conway_pkg
//  Description : Shared types and constants for the UART output path:
//                transmit-arbiter state encoding, byte width and the ASCII
//                control characters emitted by the display streamer.
//  Revision    : 1.0  initial release
// ============================================================================
package conway_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam int c_byte_w = 8;

  // ASCII characters used by the display path
  localparam logic [7:0] c_ascii_esc  = 8'h1B;
  localparam logic [7:0] c_ascii_lbr  = 8'h5B;
  localparam logic [7:0] c_ascii_semi = 8'h3B;
  localparam logic [7:0] c_ascii_h    = 8'h48;
  localparam logic [7:0] c_ascii_cr   = 8'h0D;
  localparam logic [7:0] c_ascii_lf   = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans the request vector
//                starting one position after rr_ptr (wrapping) and returns
//                the first asserted request as a one-hot winner.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  win,
  output logic             any
);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // First requester after rr_ptr in circular order wins
  always_comb begin
    win     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = PTR_W'((int'(rr_ptr) + off) % NREQ);
      if (!w_found && req[w_idx]) begin
        win[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
    any = w_found;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter among NREQ byte-stream
//                requesters. Round-robin grant, locked until the owner sends
//                a byte flagged last, with an optional idle-hold timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
  import conway_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int HOLD_MAX = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [c_byte_w*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          grant,
  output logic                     tx_valid,
  output logic [c_byte_w-1:0]      tx_data,
  input  logic                     tx_ready,
  output logic                     timeout_pulse
);

  localparam int PTR_W  = $clog2(NREQ);
  // Timeout disabled still needs a 1-bit counter to keep widths legal
  localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  arb_state_t          r_state,    w_state_nxt;
  logic [NREQ-1:0]     r_grant,    w_grant_nxt;
  logic [PTR_W-1:0]    r_rr_ptr,   w_rr_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic                r_last_q,   w_last_q_nxt;
  logic [c_byte_w-1:0] r_tx_data,  w_tx_data_nxt;
  logic                r_tx_valid, w_tx_valid_nxt;

  logic [NREQ-1:0]     w_ready;
  logic                w_timeout;
  logic [NREQ-1:0]     w_win;
  logic                w_any;
  logic [PTR_W-1:0]    w_owner;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .win    (w_win),
    .any    (w_any)
  );

  // Binary index of the current lock owner
  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_owner = PTR_W'(i);
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    w_last_q_nxt   = r_last_q;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_ready        = '0;
    w_timeout      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt    = w_win;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = FETCH;
        end
      end
      FETCH: begin
        w_ready[w_owner] = req_valid[w_owner];
        if (req_valid[w_owner]) begin
          // A byte on offer beats a coincident timeout so it is never lost
          w_tx_data_nxt = req_data[{w_owner, 3'b000} +: c_byte_w];
          w_last_q_nxt  = req_last[w_owner];
          w_state_nxt   = SEND;
        end else if ((HOLD_MAX != 0) && (r_hold_cnt == HOLD_W'(HOLD_MAX))) begin
          w_timeout    = 1'b1;
          w_rr_ptr_nxt = w_owner;
          w_grant_nxt  = '0;
          w_state_nxt  = IDLE;
        end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ACK;
        end
      end
      ACK: begin
        // Ready dropping means the transmitter has taken the byte
        if (!tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          if (r_last_q) begin
            w_rr_ptr_nxt = w_owner;
            w_grant_nxt  = '0;
            w_state_nxt  = IDLE;
          end else begin
            w_hold_cnt_nxt = '0;
            w_state_nxt    = FETCH;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= PTR_W'(NREQ - 1);
      r_hold_cnt <= '0;
      r_last_q   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_last_q   <= w_last_q_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  assign req_ready     = w_ready;
  assign grant         = r_grant;
  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign timeout_pulse = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter with a small UART
//                transmitter model and queue-driven requesters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ     = 3;
  localparam int HOLD_MAX = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              timeout_pulse;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] g;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] rq[NREQ][$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       force_busy = 1'b0;
  int         busy = 0;
  logic [NREQ-1:0] fire;
  logic       m_acc;
  logic [7:0] m_d;
  logic [2:0] m_g;
  exp_t       m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_b(input logic [7:0] d, input logic [2:0] g);
    exp_t e;
    e.d = d;
    e.g = g;
    sb.push_back(e);
  endtask

  // Requesters: present queue head, pop after a handshake edge
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[8*i +: 8]   = rq[i][0][7:0];
          req_last[i]          = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model and scoreboard monitor
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      m_acc = tx_valid && tx_ready;
      m_d   = tx_data;
      m_g   = grant;
      @(posedge clk);
      m_acc = m_acc && rst_n;
      if (m_acc) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", m_d, $time);
        end else begin
          m_e = sb.pop_front();
          chk("tx_data", {24'd0, m_d}, {24'd0, m_e.d});
          chk("tx_grant", {29'd0, m_g}, {29'd0, m_e.g});
        end
        busy = 4;
      end else if (busy > 0) begin
        busy--;
      end
      #1;
      tx_ready = (busy == 0) && !force_busy;
    end
  end

  task automatic wait_done(input string name, input int max);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && (rq[0].size() == 0) && (rq[1].size() == 0) &&
             (rq[2].size() == 0) && (req_valid == '0) && (grant == '0) &&
             !tx_valid && tx_ready;
      if (done) break;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_sb(input string name, input int lvl, input int max);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (sb.size() <= lvl) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    @(negedge clk);
  endtask

  task automatic leave_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   k;
    logic ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {29'd0, grant}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_pulse}, 32'd0);
    rst_n = 1'b1;

    // Single requester, ESC [ ; H
    push(0, 8'h1B, 1'b0); push(0, 8'h5B, 1'b0);
    push(0, 8'h3B, 1'b0); push(0, 8'h48, 1'b1);
    expect_b(8'h1B, 3'b001); expect_b(8'h5B, 3'b001);
    expect_b(8'h3B, 3'b001); expect_b(8'h48, 3'b001);
    wait_done("t1_drain", 300);
    chk("t1_grant_released", {29'd0, grant}, 32'd0);

    // Requesters 0 and 2 together; a late request on 0 waits for 2
    enter_reset();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b1);
    push(2, 8'h43, 1'b0); push(2, 8'h44, 1'b1);
    expect_b(8'h41, 3'b001); expect_b(8'h42, 3'b001);
    expect_b(8'h43, 3'b100); expect_b(8'h44, 3'b100);
    expect_b(8'h45, 3'b001);
    leave_reset();
    wait_sb("t2_first_byte", 4, 200);
    push(0, 8'h45, 1'b1);
    wait_done("t2_drain", 400);

    // Requester 1 streams xyz, requester 0 arrives mid-packet
    enter_reset();
    push(1, 8'h78, 1'b0); push(1, 8'h79, 1'b0); push(1, 8'h7A, 1'b1);
    expect_b(8'h78, 3'b010); expect_b(8'h79, 3'b010);
    expect_b(8'h7A, 3'b010); expect_b(8'h51, 3'b001);
    leave_reset();
    wait_sb("t3_first_byte", 3, 200);
    push(0, 8'h51, 1'b1);
    wait_done("t3_drain", 400);

    // Hold timeout: requester 0 stalls after a non-last byte
    enter_reset();
    push(0, 8'h61, 1'b0);
    push(1, 8'h62, 1'b1);
    expect_b(8'h61, 3'b001); expect_b(8'h62, 3'b010);
    leave_reset();
    wait_sb("t4_first_byte", 1, 200);
    ok = 1'b0;
    for (int j = 0; j < 50; j++) begin
      if (!tx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_fetch_reentry", {31'd0, ok}, 32'd1);
    k = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      k++;
      if (timeout_pulse) break;
    end
    chk("t4_timeout_cycles", k, 16);
    chk("t4_grant_at_pulse", {29'd0, grant}, 32'd1);
    @(negedge clk);
    chk("t4_pulse_width", {31'd0, timeout_pulse}, 32'd0);
    chk("t4_grant_revoked", {29'd0, grant}, 32'd0);
    wait_done("t4_drain", 300);

    // Async reset while in ACK
    enter_reset();
    push(0, 8'h50, 1'b1);
    expect_b(8'h50, 3'b001);
    leave_reset();
    wait_done("t5_pre_drain", 200);
    push(0, 8'h52, 1'b0); push(0, 8'h53, 1'b1);
    ok = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_reach_ack", {31'd0, ok}, 32'd1);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    #1;
    chk("t5_async_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("t5_async_grant", {29'd0, grant}, 32'd0);
    chk("t5_async_req_ready", {29'd0, req_ready}, 32'd0);
    @(negedge clk);
    push(0, 8'h54, 1'b1); push(1, 8'h55, 1'b1);
    expect_b(8'h54, 3'b001); expect_b(8'h55, 3'b010);
    leave_reset();
    wait_done("t5_drain", 300);

    // Transmitter busy for 100 cycles while a byte waits in SEND
    enter_reset();
    leave_reset();
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    push(0, 8'h5A, 1'b1);
    expect_b(8'h5A, 3'b001);
    k = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (tx_valid) k++;
    end
    chk("t6_no_valid_while_busy", k, 0);
    chk("t6_grant_held", {29'd0, grant}, 32'd1);
    force_busy = 1'b0;
    wait_done("t6_drain", 200);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
